// File: rtl/irq_pkg.sv
// Shared constants and types for the machine-level interrupt request unit:
// mcause values, MMIO offsets, mie/mip bit positions and the request FSM states.
package irq_pkg;

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    localparam logic [4:0] OFF_MSIP        = 5'h00;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h08;
    localparam logic [4:0] OFF_MTIME_LO    = 5'h0C;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h10;

    localparam int MSI_BIT = 3;
    localparam int MTI_BIT = 7;
    localparam int MEI_BIT = 11;

    localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        TRAP = 2'd2
    } irq_state_e;

    // Fixed priority among enabled pending sources: external, software, timer.
    function automatic logic [31:0] highest_cause(input logic mei, input logic msi,
                                                  input logic mti);
        logic [31:0] cause;
        cause = '0;
        if (mei)      cause = CAUSE_MEI;
        else if (msi) cause = CAUSE_MSI;
        else if (mti) cause = CAUSE_MTI;
        return cause;
    endfunction

endpackage

// File: rtl/irq_ext_sync.sv
// Multi-flop synchronizer for the asynchronous external interrupt line,
// followed by a rising-edge detector that emits a single-cycle pulse.
module irq_ext_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: non-blocking assignments make every stage sample its neighbour's
    // pre-edge value; blocking ones would collapse the chain into one flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_request_unit.sv
// Machine interrupt source: mtime/mtimecmp timer, msip, external capture,
// priority selection and the request/trap/mret handshake with the exception unit.
module irq_request_unit
    import irq_pkg::*;
#(
    parameter int PRESCALE    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_we,
    input  logic [4:0]  mmio_addr,
    input  logic [31:0] mmio_wdata,
    output logic [31:0] mmio_rdata,
    input  logic        mstatus_mie,
    input  logic [31:0] mie,
    input  logic        ext_irq,
    input  logic        trap_ack,
    input  logic        mret,
    output logic        interrupt,
    output logic [31:0] irq_cause,
    output logic [31:0] mip
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] prescale_q;
    logic [63:0]     mtime_q;
    logic [63:0]     mtimecmp_q;
    logic            msip_q;
    logic            meip_q;
    irq_state_e      state_q;
    logic [31:0]     cause_q;

    logic            ext_rise;
    logic            mtip;
    logic [31:0]     active;
    logic            take_irq;
    logic            ack_req;

    logic wr_msip, wr_cmp_lo, wr_cmp_hi, wr_mtime_lo, wr_mtime_hi;

    irq_ext_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ext_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(ext_irq),
        .rise    (ext_rise)
    );

    assign wr_msip     = mmio_we && (mmio_addr == OFF_MSIP);
    assign wr_cmp_lo   = mmio_we && (mmio_addr == OFF_MTIMECMP_LO);
    assign wr_cmp_hi   = mmio_we && (mmio_addr == OFF_MTIMECMP_HI);
    assign wr_mtime_lo = mmio_we && (mmio_addr == OFF_MTIME_LO);
    assign wr_mtime_hi = mmio_we && (mmio_addr == OFF_MTIME_HI);

    // A software write to either mtime half owns that edge: no tick, prescaler restarts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime_q    <= '0;
            prescale_q <= '0;
        end else if (wr_mtime_lo) begin
            mtime_q[31:0] <= mmio_wdata;
            prescale_q    <= '0;
        end else if (wr_mtime_hi) begin
            mtime_q[63:32] <= mmio_wdata;
            prescale_q     <= '0;
        end else if (prescale_q == PS_LAST) begin
            mtime_q    <= mtime_q + 64'd1;
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mtimecmp_q <= MTIMECMP_RESET;
            msip_q     <= 1'b0;
        end else begin
            if (wr_cmp_lo) mtimecmp_q[31:0]  <= mmio_wdata;
            if (wr_cmp_hi) mtimecmp_q[63:32] <= mmio_wdata;
            if (wr_msip)   msip_q            <= mmio_wdata[0];
        end
    end

    assign mtip = (mtime_q >= mtimecmp_q);

    // NOTE: every variable driven in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mip          = '0;
        mip[MSI_BIT] = msip_q;
        mip[MTI_BIT] = mtip;
        mip[MEI_BIT] = meip_q;
    end

    assign active   = mip & mie & IRQ_MASK;
    assign take_irq = (state_q == IDLE) && mstatus_mie && (|active);
    assign ack_req  = (state_q == REQ) && trap_ack;

    // A fresh edge beats the clear, so an interrupt arriving with its own ack is not lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meip_q <= 1'b0;
        end else if (ext_rise) begin
            meip_q <= 1'b1;
        end else if (ack_req && (cause_q == CAUSE_MEI)) begin
            meip_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cause_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_irq) begin
                        state_q <= REQ;
                        cause_q <= highest_cause(active[MEI_BIT], active[MSI_BIT],
                                                 active[MTI_BIT]);
                    end
                end
                REQ: begin
                    if (trap_ack) state_q <= TRAP;
                end
                TRAP: begin
                    if (mret) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign interrupt = (state_q == REQ);
    assign irq_cause = cause_q;

    always_comb begin
        mmio_rdata = '0;
        case (mmio_addr)
            OFF_MSIP:        mmio_rdata = {31'b0, msip_q};
            OFF_MTIMECMP_LO: mmio_rdata = mtimecmp_q[31:0];
            OFF_MTIMECMP_HI: mmio_rdata = mtimecmp_q[63:32];
            OFF_MTIME_LO:    mmio_rdata = mtime_q[31:0];
            OFF_MTIME_HI:    mmio_rdata = mtime_q[63:32];
            default:         mmio_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_request_unit.sv
// Bench for irq_request_unit: register table, directed corner sequences and a
// randomized run compared against a behavioural model of the interrupt unit.
module tb_irq_request_unit;

    localparam int PRESCALE    = 1;
    localparam int SYNC_STAGES = 2;

    localparam logic [31:0] C_MEI = 32'h8000_000B;
    localparam logic [31:0] C_MSI = 32'h8000_0003;
    localparam logic [31:0] C_MTI = 32'h8000_0007;

    logic        clk = 1'b0;
    logic        rst;
    logic        mmio_we;
    logic [4:0]  mmio_addr;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        mstatus_mie;
    logic [31:0] mie;
    logic        ext_irq;
    logic        trap_ack;
    logic        mret;
    logic        interrupt;
    logic [31:0] irq_cause;
    logic [31:0] mip;

    int checks = 0;
    int errors = 0;

    irq_request_unit #(
        .PRESCALE   (PRESCALE),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mmio_we    (mmio_we),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_rdata (mmio_rdata),
        .mstatus_mie(mstatus_mie),
        .mie        (mie),
        .ext_irq    (ext_irq),
        .trap_ack   (trap_ack),
        .mret       (mret),
        .interrupt  (interrupt),
        .irq_cause  (irq_cause),
        .mip        (mip)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    longint unsigned m_mtime;
    longint unsigned m_cmp;
    int              m_ps;
    bit              m_msip;
    bit              m_meip;
    bit              m_req;
    bit              m_trap;
    bit [31:0]       m_cause;
    bit              ext_hist[$];

    function automatic bit [31:0] m_mip();
        bit [31:0] v;
        v     = '0;
        v[3]  = m_msip;
        v[7]  = (m_mtime >= m_cmp);
        v[11] = m_meip;
        return v;
    endfunction

    function automatic bit [31:0] m_rdata(input logic [4:0] a);
        case (a)
            5'h00:   return {31'b0, m_msip};
            5'h04:   return m_cmp[31:0];
            5'h08:   return m_cmp[63:32];
            5'h0C:   return m_mtime[31:0];
            5'h10:   return m_mtime[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mtime  = 0;
        m_ps     = 0;
        m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip   = 0;
        m_meip   = 0;
        m_req    = 0;
        m_trap   = 0;
        m_cause  = 0;
        ext_hist = {};
        for (int i = 0; i <= SYNC_STAGES; i++) ext_hist.push_back(1'b0);
    endtask

    // One rising edge: everything is derived from pre-edge state and the inputs.
    task automatic model_update();
        bit [31:0] act;
        bit        pulse;
        bit        clr_meip;
        if (!rst) begin
            model_reset();
            return;
        end
        act      = m_mip() & mie & 32'h0000_0888;
        pulse    = ext_hist[SYNC_STAGES-1] && !ext_hist[SYNC_STAGES];
        clr_meip = 0;
        if (m_req) begin
            if (trap_ack) begin
                m_req    = 0;
                m_trap   = 1;
                clr_meip = (m_cause == C_MEI);
            end
        end else if (m_trap) begin
            if (mret) m_trap = 0;
        end else if (mstatus_mie && act != 0) begin
            m_req   = 1;
            m_cause = act[11] ? C_MEI : (act[3] ? C_MSI : C_MTI);
        end
        if (pulse) m_meip = 1;
        else if (clr_meip) m_meip = 0;
        if (mmio_we && mmio_addr == 5'h00) m_msip = mmio_wdata[0];
        if (mmio_we && mmio_addr == 5'h04) m_cmp[31:0] = mmio_wdata;
        if (mmio_we && mmio_addr == 5'h08) m_cmp[63:32] = mmio_wdata;
        if (mmio_we && (mmio_addr == 5'h0C || mmio_addr == 5'h10)) begin
            if (mmio_addr == 5'h0C) m_mtime[31:0] = mmio_wdata;
            else m_mtime[63:32] = mmio_wdata;
            m_ps = 0;
        end else if (m_ps == PRESCALE - 1) begin
            m_ps    = 0;
            m_mtime = m_mtime + 1;
        end else begin
            m_ps = m_ps + 1;
        end
        ext_hist.push_front(ext_irq);
        void'(ext_hist.pop_back());
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic mmio_write(input logic [4:0] a, input logic [31:0] d);
        mmio_we    = 1'b1;
        mmio_addr  = a;
        mmio_wdata = d;
        tick();
        mmio_we = 1'b0;
    endtask

    task automatic pulse_ack();
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    task automatic wait_irq(input string name, input int budget);
        for (int i = 0; i < budget && interrupt !== 1'b1; i++) tick();
        check(name, {31'b0, interrupt}, 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        rst = 1'b0; mmio_we = 1'b0; mmio_addr = '0; mmio_wdata = '0;
        mstatus_mie = 1'b0; mie = '0; ext_irq = 1'b0; trap_ack = 1'b0; mret = 1'b0;
        model_reset();

        // ---- reset state ----
        tick();
        check("reset_interrupt", {31'b0, interrupt}, 32'd0);
        check("reset_cause", irq_cause, 32'd0);
        check("reset_mip", mip, 32'd0);
        mmio_addr = 5'h08; #1;
        check("reset_cmp_hi", mmio_rdata, 32'hFFFF_FFFF);
        mmio_addr = 5'h04; #1;
        check("reset_cmp_lo", mmio_rdata, 32'hFFFF_FFFF);
        mmio_addr = 5'h0C; #1;
        check("reset_mtime_lo", mmio_rdata, 32'd0);
        rst = 1'b1;

        // ---- register table: write (if any) then read back ----
        vecs[0]  = '{1'b1, 5'h00, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[1]  = '{1'b1, 5'h00, 32'hFFFF_FFFE, 32'h0000_0000};
        vecs[2]  = '{1'b1, 5'h04, 32'h1234_5678, 32'h1234_5678};
        vecs[3]  = '{1'b1, 5'h08, 32'h0000_0001, 32'h0000_0001};
        vecs[4]  = '{1'b1, 5'h0C, 32'h0000_0100, 32'h0000_0100};
        vecs[5]  = '{1'b1, 5'h10, 32'h0000_0002, 32'h0000_0002};
        vecs[6]  = '{1'b0, 5'h14, 32'h0,         32'h0000_0000};
        vecs[7]  = '{1'b1, 5'h1F, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8]  = '{1'b0, 5'h02, 32'h0,         32'h0000_0000};
        vecs[9]  = '{1'b1, 5'h00, 32'h0000_0001, 32'h0000_0001};
        vecs[10] = '{1'b1, 5'h08, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[11] = '{1'b0, 5'h04, 32'h0,         32'h1234_5678};
        for (int i = 0; i < 12; i++) begin
            mmio_addr  = vecs[i].addr;
            mmio_wdata = vecs[i].wdata;
            mmio_we    = vecs[i].we;
            if (vecs[i].we) tick();
            mmio_we = 1'b0;
            #1;
            check($sformatf("table_%0d", i), mmio_rdata, vecs[i].exp);
        end
        mmio_write(5'h00, 32'h0);

        // ---- read in the write cycle sees the old value ----
        mmio_we = 1'b1; mmio_addr = 5'h04; mmio_wdata = 32'hA5A5_A5A5; #1;
        check("same_cycle_old", mmio_rdata, 32'h1234_5678);
        tick();
        mmio_we = 1'b0; #1;
        check("next_cycle_new", mmio_rdata, 32'hA5A5_A5A5);

        // ---- 64-bit wrap and write-vs-tick ----
        mmio_write(5'h10, 32'hFFFF_FFFF);
        mmio_write(5'h0C, 32'hFFFF_FFFF);
        mmio_addr = 5'h0C; #1;
        check("wrap_pre_lo", mmio_rdata, 32'hFFFF_FFFF);
        mmio_addr = 5'h10; #1;
        check("wrap_pre_hi", mmio_rdata, 32'hFFFF_FFFF);
        tick();
        mmio_addr = 5'h0C; #1;
        check("wrap_lo", mmio_rdata, 32'h0);
        mmio_addr = 5'h10; #1;
        check("wrap_hi", mmio_rdata, 32'h0);
        mmio_write(5'h0C, 32'h0000_0055);
        mmio_addr = 5'h0C; #1;
        check("write_no_inc", mmio_rdata, 32'h0000_0055);
        tick();
        check("inc_resumes", mmio_rdata, 32'h0000_0056);

        // ---- timer interrupt, trap hold, mret re-request, reset drop ----
        do_reset();
        mie = 32'h0000_0080; mstatus_mie = 1'b1;
        mmio_write(5'h04, 32'd10);
        mmio_write(5'h08, 32'd0);
        mmio_addr = 5'h0C; #1;
        for (int i = 0; i < 40 && mmio_rdata != 32'd10; i++) tick();
        check("mtime_reaches_10", mmio_rdata, 32'd10);
        check("mtip_same_cycle", {31'b0, mip[7]}, 32'd1);
        check("no_irq_yet", {31'b0, interrupt}, 32'd0);
        tick();
        check("timer_irq", {31'b0, interrupt}, 32'd1);
        check("timer_cause", irq_cause, C_MTI);
        pulse_ack();
        check("ack_drops_irq", {31'b0, interrupt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("trap_blocks", {31'b0, interrupt, mip[7]}, 32'd1);
        end
        pulse_mret();
        check("mret_plus1", {31'b0, interrupt}, 32'd0);
        tick();
        check("mret_plus2", {31'b0, interrupt}, 32'd1);
        rst = 1'b0;
        tick();
        check("rst_drops_irq", {31'b0, interrupt}, 32'd0);
        rst = 1'b1;

        // ---- priority MEI > MSI, then hold, then ack+mret together ----
        mie = 32'h0000_0888; mstatus_mie = 1'b0;
        mmio_write(5'h00, 32'd1);
        ext_irq = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("both_pending", mip, 32'h0000_0808);
        mstatus_mie = 1'b1;
        tick();
        check("prio_irq", {31'b0, interrupt}, 32'd1);
        check("prio_mei", irq_cause, C_MEI);
        pulse_ack();
        check("meip_cleared", mip, 32'h0000_0008);
        pulse_mret();
        tick();
        check("prio_msi", irq_cause, C_MSI);
        mstatus_mie = 1'b0; mie = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_cause", {interrupt, irq_cause[30:0]}, {1'b1, C_MSI[30:0]});
        end
        mstatus_mie = 1'b1; mie = 32'h0000_0888;
        trap_ack = 1'b1; mret = 1'b1;
        tick();
        trap_ack = 1'b0; mret = 1'b0;
        check("ack_mret_trap1", {31'b0, interrupt}, 32'd0);
        tick();
        check("ack_mret_trap2", {31'b0, interrupt}, 32'd0);
        mmio_write(5'h00, 32'd0);
        pulse_mret();
        tick();
        check("nothing_pending", {31'b0, interrupt}, 32'd0);

        // ---- new ext edge coinciding with the MEI ack ----
        ext_irq = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        ext_irq = 1'b1;
        wait_irq("mei_request", 10);
        check("mei_cause", irq_cause, C_MEI);
        ext_irq = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        ext_irq = 1'b1;
        tick();
        tick();
        pulse_ack();
        check("coincide_no_irq", {31'b0, interrupt}, 32'd0);
        check("meip_kept", {31'b0, mip[11]}, 32'd1);
        pulse_mret();
        check("coincide_mret1", {31'b0, interrupt}, 32'd0);
        tick();
        check("mei_rerequest", {interrupt, irq_cause[30:0]}, {1'b1, C_MEI[30:0]});

        // ---- randomized run against the model ----
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 299) != 0);
            mmio_we = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 5))
                0:       mmio_addr = 5'h00;
                1:       mmio_addr = 5'h04;
                2:       mmio_addr = 5'h08;
                3:       mmio_addr = 5'h0C;
                4:       mmio_addr = 5'h10;
                default: mmio_addr = 5'($urandom);
            endcase
            mmio_wdata  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64));
            mstatus_mie = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mie = $urandom;
            if ($urandom_range(0, 5) == 0) ext_irq = ~ext_irq;
            trap_ack = ($urandom_range(0, 3) == 0);
            mret     = ($urandom_range(0, 4) == 0);
            #1;
            check("rnd_interrupt", {31'b0, interrupt}, {31'b0, m_req});
            check("rnd_cause", irq_cause, m_cause);
            check("rnd_mip", mip, m_mip());
            check("rnd_rdata", mmio_rdata, m_rdata(mmio_addr));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
